rmt_ingress_arb: RTL and testbench

RMT_INGRESS_ARB -- requirements
Module: rmt_ingress_arb

---
 rtl/rmt_ingress_arb.sv | 176 +++++++++++++++++
 tb/tb_rmt_ingress_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_ingress_arb.sv
// Packet-granular N:1 AXI-Stream ingress arbiter with registered output,
// optional source-port stamping in tuser and per-port forwarded-packet counters.
module rmt_ingress_arb #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int ARB_MODE             = 0,
    parameter int STAMP_EN             = 1,
    parameter int SRC_PORT_LSB         = 16,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                                          clk,
    input  logic                                          aresetn,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                          s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                          s_axis_tlast,
    output logic [NUM_PORTS-1:0]                          s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                          m_axis_tvalid,
    output logic                                          m_axis_tlast,
    input  logic                                          m_axis_tready,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]                pkt_cnt
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   grant_next;
    logic            out_ready;
    logic            accept;
    logic            last_accept;
    logic [DW-1:0]   sel_tdata;
    logic [KW-1:0]   sel_tkeep;
    logic [UW-1:0]   sel_tuser;
    logic [UW-1:0]   stamped_tuser;
    logic            sel_tvalid;
    logic            sel_tlast;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];

    assign out_ready   = ~m_axis_tvalid | m_axis_tready;
    assign accept      = (state_q == LOCKED) && sel_tvalid && out_ready;
    assign last_accept = accept && sel_tlast;
    assign grant_next  = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tuser  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == GW'(p)) begin
                sel_tdata  = s_axis_tdata[p*DW +: DW];
                sel_tkeep  = s_axis_tkeep[p*KW +: KW];
                sel_tuser  = s_axis_tuser[p*UW +: UW];
                sel_tvalid = s_axis_tvalid[p];
                sel_tlast  = s_axis_tlast[p];
            end
        end
    end

    always_comb begin
        stamped_tuser = sel_tuser;
        if (STAMP_EN != 0) begin
            stamped_tuser[SRC_PORT_LSB +: 8] = 8'd1 << {grant_q, 1'b0};
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            s_axis_tready[p] = (state_q == LOCKED) && (grant_q == GW'(p)) && out_ready;
        end
    end

    // Wrapped upward search; fixed priority is the same search anchored at port 0.
    always_comb begin
        int unsigned start;
        int unsigned idx;
        logic        found;
        pick  = '0;
        found = 1'b0;
        start = (ARB_MODE == 1) ? 0 : 32'(rr_ptr_q);
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (start + k) % NUM_PORTS;
            if (!found && s_axis_tvalid[GW'(idx)]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    state_d = LOCKED;
                    grant_d = pick;
                end
            end
            LOCKED: begin
                if (last_accept) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= sel_tlast;
            m_axis_tdata  <= sel_tdata;
            m_axis_tkeep  <= sel_tkeep;
            m_axis_tuser  <= stamped_tuser;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (last_accept && (grant_q == GW'(p))) begin
                    cnt_q[p] <= cnt_q[p] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
        end
    end

endmodule

// File: tb/tb_rmt_ingress_arb.sv
// Randomised bench for rmt_ingress_arb: AXIS sources with gaps and stalls,
// checked each cycle against a packet-level arbitration reference model.
module tb_rmt_ingress_arb;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int UW   = 32;
    localparam int CW   = 4;
    localparam int FCW  = 8;
    localparam int LSB  = 16;
    localparam int MODE = 0;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N*UW-1:0] s_tuser;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid, m_tlast, m_tready;
    logic [N*CW-1:0] pkt_cnt;

    logic [N-1:0]     fp_tready;
    logic [DW-1:0]    fp_tdata;
    logic [KW-1:0]    fp_tkeep;
    logic [UW-1:0]    fp_tuser;
    logic             fp_tvalid, fp_tlast;
    logic [N*FCW-1:0] fp_cnt;

    rmt_ingress_arb #(
        .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(N),
        .ARB_MODE(MODE), .STAMP_EN(1), .SRC_PORT_LSB(LSB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .pkt_cnt(pkt_cnt)
    );

    // Fixed-priority instance: ports 1 and 3 request continuously with 1-beat packets.
    rmt_ingress_arb #(
        .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(N),
        .ARB_MODE(1), .STAMP_EN(1), .SRC_PORT_LSB(LSB), .CNT_WIDTH(FCW)
    ) dut_fp (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(4'b1010), .s_axis_tlast(4'b1010), .s_axis_tready(fp_tready),
        .m_axis_tdata(fp_tdata), .m_axis_tkeep(fp_tkeep), .m_axis_tuser(fp_tuser),
        .m_axis_tvalid(fp_tvalid), .m_axis_tlast(fp_tlast), .m_axis_tready(1'b1),
        .pkt_cnt(fp_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Source state
    int unsigned   src_left [N];
    int unsigned   src_sent [N];
    bit            src_show [N];
    logic [DW-1:0] src_data [N];
    logic [KW-1:0] src_keep [N];
    logic [UW-1:0] src_user [N];

    // Stimulus controls
    logic [N-1:0] en_mask;
    bit           always_rdy;
    bit           greedy;
    int unsigned  force_len;

    // Reference model
    bit            mdl_busy;
    int unsigned   mdl_owner;
    int unsigned   mdl_rr;
    bit            exp_valid;
    bit            exp_last;
    logic [DW-1:0] exp_data;
    logic [KW-1:0] exp_keep;
    logic [UW-1:0] exp_user;
    int unsigned   exp_cnt [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_busy  = 1'b0;
        mdl_owner = 0;
        mdl_rr    = 0;
        exp_valid = 1'b0;
        for (int p = 0; p < N; p++) begin
            exp_cnt[p]  = 0;
            src_left[p] = 0;
            src_sent[p] = 0;
            src_show[p] = 1'b0;
        end
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_mlast"},  64'(m_tlast), 64'd0);
        chk({tag, "_mdata"},  64'({m_tdata, m_tkeep}), 64'd0);
        chk({tag, "_muser"},  64'(m_tuser), 64'd0);
        chk({tag, "_sready"}, 64'(s_tready), 64'd0);
        chk({tag, "_cnt"},    64'(pkt_cnt), 64'd0);
        chk({tag, "_fpcnt"},  64'(fp_cnt), 64'd0);
    endtask

    task automatic step();
        logic [N-1:0]    er;
        logic [N*CW-1:0] ec;
        bit              room;
        bit              took;
        bit              found;
        int unsigned     q;
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
            if (!src_show[p]) begin
                if (src_left[p] == 0 && en_mask[p] && (greedy || $urandom % 3 == 0)) begin
                    src_left[p] = (force_len != 0) ? force_len : 1 + $urandom % 5;
                    src_sent[p] = 0;
                end
                if (src_left[p] != 0 && (greedy || $urandom % 4 != 0)) begin
                    src_show[p] = 1'b1;
                    src_data[p] = $urandom;
                    src_keep[p] = KW'($urandom);
                    src_user[p] = $urandom;
                end
            end
            s_tvalid[p] = src_show[p];
            s_tlast[p]  = src_show[p] && src_left[p] == 1;
            s_tdata[p*DW +: DW] = src_data[p];
            s_tkeep[p*KW +: KW] = src_keep[p];
            s_tuser[p*UW +: UW] = src_user[p];
        end
        m_tready = always_rdy ? 1'b1 : ($urandom % 3 != 0);
        #1;
        chk("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
        if (exp_valid) begin
            chk("m_tdata", 64'(m_tdata), 64'(exp_data));
            chk("m_tkeep", 64'(m_tkeep), 64'(exp_keep));
            chk("m_tuser", 64'(m_tuser), 64'(exp_user));
            chk("m_tlast", 64'(m_tlast), 64'(exp_last));
        end
        room = !exp_valid || m_tready;
        er = '0;
        if (mdl_busy && room) er[mdl_owner] = 1'b1;
        chk("s_tready", 64'(s_tready), 64'(er));
        for (int p = 0; p < N; p++) ec[p*CW +: CW] = CW'(exp_cnt[p]);
        chk("pkt_cnt", 64'(pkt_cnt), 64'(ec));
        chk("fp_ready_mask", 64'(fp_tready & 4'b1101), 64'd0);
        if (fp_tvalid) chk("fp_stamp", 64'(fp_tuser[LSB +: 8]), 64'h04);

        took = 1'b0;
        if (mdl_busy && src_show[mdl_owner] && room) begin
            took      = 1'b1;
            exp_data  = src_data[mdl_owner];
            exp_keep  = src_keep[mdl_owner];
            exp_user  = src_user[mdl_owner];
            exp_user[LSB +: 8] = 8'(1 << (2 * mdl_owner));
            exp_last  = (src_left[mdl_owner] == 1);
            src_show[mdl_owner] = 1'b0;
            src_left[mdl_owner]--;
            src_sent[mdl_owner]++;
            if (exp_last) begin
                mdl_busy = 1'b0;
                exp_cnt[mdl_owner] = (exp_cnt[mdl_owner] + 1) % (1 << CW);
                mdl_rr = (mdl_owner + 1) % N;
            end
        end else if (!mdl_busy && s_tvalid != 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                q = ((MODE == 1 ? 0 : mdl_rr) + k) % N;
                if (!found && src_show[q]) begin
                    found     = 1'b1;
                    mdl_owner = q;
                end
            end
            mdl_busy = 1'b1;
        end
        if (took) exp_valid = 1'b1;
        else if (m_tready) exp_valid = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        bit ok;
        aresetn    = 1'b0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tuser    = '0;
        m_tready   = 1'b0;
        en_mask    = '0;
        always_rdy = 1'b1;
        greedy     = 1'b0;
        force_len  = 0;
        model_reset();
        #1;
        check_reset_state("por");
        repeat (3) @(negedge clk);
        aresetn = 1'b1;

        // Port 2 alone, 3-beat packets, downstream always ready
        en_mask = 4'b0100; force_len = 3;
        run(30);
        en_mask = '0;
        run(20);
        chk("p2_cnt_nonzero", 64'(pkt_cnt[2*CW +: CW] != 0), 64'd1);

        // All ports, random lengths, gaps and back-pressure
        en_mask = '1; force_len = 0; always_rdy = 1'b0;
        run(1500);

        // All ports greedy with 1-beat packets: strict rotation, one idle cycle between
        greedy = 1'b1; force_len = 1; always_rdy = 1'b1;
        run(300);
        greedy = 1'b0; en_mask = '0;
        run(60);

        // Reset in the middle of a 5-beat packet from port 0
        en_mask = 4'b0001; force_len = 5; greedy = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (mdl_busy && mdl_owner == 0 && src_sent[0] == 2) ok = 1'b1;
        end
        chk("rst_setup_reached", 64'(ok), 64'd1);
        #1 aresetn = 1'b0;
        #1;
        model_reset();
        check_reset_state("midrst");
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        run(40);
        chk("post_rst_cnt0", 64'(pkt_cnt[CW-1:0] != 0), 64'd1);

        // Random mix again
        en_mask = '1; force_len = 0; greedy = 1'b0; always_rdy = 1'b0;
        run(1200);
        en_mask = '0; always_rdy = 1'b1;
        run(60);

        chk("fp_cnt_port3", 64'(fp_cnt[3*FCW +: FCW]), 64'd0);
        chk("fp_cnt_port1_served", 64'(fp_cnt[1*FCW +: FCW] != 0), 64'd1);
        chk("fp_cnt_others", 64'({fp_cnt[2*FCW +: FCW], fp_cnt[0 +: FCW]}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
